// File: rtl/wired_lsu_stbuf_if.sv
// Store-buffer bus bundle: M1 enqueue, C commit/flush, dcache write-back
// handshake, load forwarding query, and occupancy status.
//   master : the LSU side (drives push/commit/flush/wb_ready/ld_addr)
//   slave  : the store buffer (drives push_ready, wb_*, fwd_*, cnt, empty)
interface wired_lsu_stbuf_if #(
    parameter int DEPTH = 8,
    parameter int AW    = 30,
    parameter int DW    = 32
);
    localparam int SW = DW / 8;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          push_valid_i;
    logic          push_ready_o;
    logic [AW-1:0] push_addr_i;
    logic [DW-1:0] push_data_i;
    logic [SW-1:0] push_strb_i;
    logic          commit_i;
    logic          flush_i;
    logic          wb_valid_o;
    logic          wb_ready_i;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_data_o;
    logic [SW-1:0] wb_strb_o;
    logic [AW-1:0] ld_addr_i;
    logic [SW-1:0] fwd_mask_o;
    logic [DW-1:0] fwd_data_o;
    logic [CW-1:0] cnt_o;
    logic          empty_o;

    modport master (
        output push_valid_i, push_addr_i, push_data_i, push_strb_i,
        output commit_i, flush_i, wb_ready_i, ld_addr_i,
        input  push_ready_o, wb_valid_o, wb_addr_o, wb_data_o, wb_strb_o,
        input  fwd_mask_o, fwd_data_o, cnt_o, empty_o
    );

    modport slave (
        input  push_valid_i, push_addr_i, push_data_i, push_strb_i,
        input  commit_i, flush_i, wb_ready_i, ld_addr_i,
        output push_ready_o, wb_valid_o, wb_addr_o, wb_data_o, wb_strb_o,
        output fwd_mask_o, fwd_data_o, cnt_o, empty_o
    );
endinterface

// File: rtl/wired_lsu_stbuf.sv
// LSU store buffer: parametrised circular queue of DEPTH entries.
// Stores enqueue at tail, commit in order via cptr, and drain from head
// to the dcache over a valid/ready handshake. Flush drops uncommitted
// entries only. Byte-granular store-to-load forwarding picks the youngest
// matching valid entry per byte.
// Ports: clk, rst (sync, active high), bus (wired_lsu_stbuf_if.slave).
module wired_lsu_stbuf #(
    parameter int DEPTH = 8,
    parameter int AW    = 30,
    parameter int DW    = 32
) (
    input logic              clk,
    input logic              rst,
    wired_lsu_stbuf_if.slave bus
);
    localparam int SW = DW / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head, cptr, tail;
    logic [CW-1:0]    cnt, ccnt;
    logic [DEPTH-1:0] vld, cmt;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [SW-1:0]    strb_q [DEPTH];

    logic          push_ready, wb_valid;
    logic          push_fire, commit_fire, drain_fire;
    logic [PW-1:0] cptr_nxt;
    logic [CW-1:0] ccnt_nxt;
    logic [PW-1:0] idx;
    logic [SW-1:0] fwd_mask;
    logic [DW-1:0] fwd_data;

    always_comb begin
        push_ready  = (cnt != CW'(DEPTH));
        wb_valid    = vld[head] & cmt[head];
        push_fire   = bus.push_valid_i & push_ready & ~bus.flush_i;
        commit_fire = bus.commit_i & (cnt != ccnt);
        drain_fire  = wb_valid & bus.wb_ready_i;
        cptr_nxt    = commit_fire ? cptr + PW'(1) : cptr;
        ccnt_nxt    = ccnt + CW'(commit_fire) - CW'(drain_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            cptr <= '0;
            tail <= '0;
            cnt  <= '0;
            ccnt <= '0;
            vld  <= '0;
            cmt  <= '0;
        end else begin
            if (drain_fire) begin
                vld[head] <= 1'b0;
                cmt[head] <= 1'b0;
                head      <= head + PW'(1);
            end
            if (commit_fire) begin
                cmt[cptr] <= 1'b1;
            end
            cptr <= cptr_nxt;
            ccnt <= ccnt_nxt;
            if (bus.flush_i) begin
                // Uncommitted entries form the contiguous span cptr_nxt..tail-1,
                // so clearing every still-uncommitted valid entry is equivalent.
                tail <= cptr_nxt;
                cnt  <= ccnt_nxt;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (vld[i] && !cmt[i] && !(commit_fire && (PW'(i) == cptr))) begin
                        vld[i] <= 1'b0;
                    end
                end
            end else begin
                if (push_fire) begin
                    vld[tail] <= 1'b1;
                    cmt[tail] <= 1'b0;
                    tail      <= tail + PW'(1);
                end
                cnt <= cnt + CW'(push_fire) - CW'(drain_fire);
            end
        end
    end

    // Payload storage carries no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            addr_q[tail] <= bus.push_addr_i;
            data_q[tail] <= bus.push_data_i;
            strb_q[tail] <= bus.push_strb_i;
        end
    end

    // Walk oldest to youngest so a younger match overwrites an older one.
    always_comb begin
        fwd_mask = '0;
        fwd_data = '0;
        idx      = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (vld[idx] && (addr_q[idx] == bus.ld_addr_i)) begin
                for (int unsigned b = 0; b < SW; b++) begin
                    if (strb_q[idx][b]) begin
                        fwd_mask[b]         = 1'b1;
                        fwd_data[b*8 +: 8] = data_q[idx][b*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        bus.push_ready_o = push_ready;
        bus.wb_valid_o   = wb_valid;
        bus.wb_addr_o    = addr_q[head];
        bus.wb_data_o    = data_q[head];
        bus.wb_strb_o    = strb_q[head];
        bus.fwd_mask_o   = fwd_mask;
        bus.fwd_data_o   = fwd_data;
        bus.cnt_o        = cnt;
        bus.empty_o      = (cnt == '0);
    end
endmodule

// File: doc/wired_lsu_stbuf.md
Name: wired_lsu_stbuf

Overview:
Parametrised store buffer for the LSU. It replaces the fixed four-entry FIFO with a configurable-depth circular queue. Stores are enqueued at M1, marked committed in order at C, and drained to the dcache write port through a valid/ready handshake. Flush squashes only the uncommitted entries. A combinational byte-granular store-to-load forwarding port merges data from the youngest matching entries.

Parameters:
DEPTH, 8, entry count; power of two, minimum 2
AW, 30, word address width (byte offset excluded)
DW, 32, data width; multiple of 8; strobe width SW = DW/8

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
push_valid_i  in  1  enqueue request (M1)
push_ready_o  out  1  space available
push_addr_i  in  AW  store word address
push_data_i  in  DW  store data
push_strb_i  in  SW  byte enables
commit_i  in  1  commit oldest uncommitted entry (C)
flush_i  in  1  squash all uncommitted entries
wb_valid_o  out  1  committed head ready for dcache
wb_ready_i  in  1  dcache accepts write
wb_addr_o  out  AW  head address
wb_data_o  out  DW  head data
wb_strb_o  out  SW  head byte enables
ld_addr_i  in  AW  load word address for forwarding
fwd_mask_o  out  SW  bytes supplied by the buffer
fwd_data_o  out  DW  forwarded bytes; zero where mask bit is 0
cnt_o  out  $clog2(DEPTH)+1  occupied entries
empty_o  out  1  cnt_o == 0

Behaviour:
- State: three pointers of width $clog2(DEPTH). head = oldest entry; cptr = oldest uncommitted entry; tail = next free slot. Occupied count cnt and committed count ccnt, each $clog2(DEPTH)+1 bits. Per-entry valid, committed, addr, data and strb registers.
- Reset (rst=1 at posedge): all pointers and counts 0; all valid and committed bits 0. Resulting outputs: push_ready_o=1, wb_valid_o=0, cnt_o=0, empty_o=1, fwd_mask_o=0. Reset overrides every other input in that cycle.
- push_ready_o = (cnt != DEPTH), taken from registered state only. A drain in the same cycle does not open a slot.
- Push fires when push_valid_i && push_ready_o && !flush_i. On fire: write the entry at tail with valid=1, committed=0, then tail+1. Pointers wrap modulo DEPTH.
- Commit: when commit_i && (cnt - ccnt) != 0, set committed at cptr, then cptr+1 and ccnt+1. When there are no uncommitted entries, commit_i is ignored and no state changes.
- Flush: tail <= cptr after applying any same-cycle commit. Entries between the new cptr and the old tail are cleared to valid=0. cnt <= ccnt (post-commit value). Any same-cycle push is dropped. Committed entries and drain are unaffected.
- Drain: wb_valid_o = valid[head] && committed[head]. wb_addr_o, wb_data_o and wb_strb_o come from entry[head]. These outputs stay stable while wb_valid_o=1 and wb_ready_i=0. On wb_valid_o && wb_ready_i: clear the head entry, head+1, cnt-1, ccnt-1.
- Simultaneous events in one cycle: push, commit and drain all apply. Net cnt = cnt + push - drain; net ccnt = ccnt + commit - drain. A commit and a drain may target the same entry only if it was already committed; the drain uses pre-cycle state.
- Forwarding (combinational, zero latency):
  - For each byte b, scan valid entries (committed or not) whose addr == ld_addr_i and strb[b]=1.
  - The youngest such entry in age order from head toward tail, modulo wrap, supplies byte b.
  - fwd_mask_o[b]=1 in that case; otherwise fwd_mask_o[b]=0 and the data byte is 0.
  - Entries written in the current cycle are not visible until the next cycle.
- Full/empty: cnt==DEPTH gives push_ready_o=0. cnt==0 gives wb_valid_o=0 and fwd_mask_o=0. Wrap-around is transparent to age ordering.
- No internal FSM beyond the pointer queue. The drain side is a two-state view (IDLE when head is not committed, REQ when wb_valid_o=1), with no extra cycle between back-to-back drains.

Test Plan:
- Reset, then push 3 stores to addr 0x10, 0x11, 0x12 with no commit -> cnt_o=3, wb_valid_o=0. Flush -> cnt_o=0, empty_o=1, push_ready_o=1.
- DEPTH=8: push 8 stores, commit 2, hold wb_ready_i=0 -> push_ready_o=0, wb_valid_o=1 with addr of the first store, stable over 5 cycles. Set wb_ready_i=1 for 1 cycle -> cnt_o=7 and the next cycle presents the second store.
- Push A@0x20 data 0xAABBCCDD strb 0xF, then B@0x20 data 0x11223344 strb 0x3. Set ld_addr_i=0x20 -> fwd_mask_o=0xF, fwd_data_o=0xAABB3344. Query ld_addr_i=0x21 -> mask 0.
- Push 4, commit 2, then in one cycle assert commit_i and flush_i together with a push -> 3 entries remain, all committed, and the push is dropped. Drain all 3 in order -> empty_o=1.
- Wrap test: run 20 push/commit/drain cycles with DEPTH=4 and continuous wb_ready_i=1, one store per cycle -> drain order equals push order, and forwarding picks the youngest entry across the wrap boundary.
- Assert rst mid-drain while wb_valid_o=1 -> next cycle wb_valid_o=0, cnt_o=0, and the pushed-but-undrained store is not written.
